csr_exec_unit: RTL

//  Executes Zicsr instructions (CSRRW/S/C and immediate forms) for the RV32I core: reads the old CSR value,

---
 rtl/csr_exec_unit_if.sv | 32 +++
 rtl/csr_exec_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/csr_exec_unit_if.sv
// csr_exec_unit_if: request/response handshake between the pipeline
// and the CSR execute unit.
interface csr_exec_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_csr_addr;
  logic [4:0]  req_rs1_idx;
  logic [31:0] req_rs1_val;
  logic [4:0]  req_rd_idx;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_rd_idx;
  logic [31:0] rsp_rd_val;
  logic        rsp_illegal;

  modport master (
    output req_valid, req_funct3, req_csr_addr,
    output req_rs1_idx, req_rs1_val, req_rd_idx,
    input  req_ready,
    input  rsp_valid, rsp_rd_idx, rsp_rd_val, rsp_illegal,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_funct3, req_csr_addr,
    input  req_rs1_idx, req_rs1_val, req_rd_idx,
    output req_ready,
    output rsp_valid, rsp_rd_idx, rsp_rd_val, rsp_illegal,
    input  rsp_ready
  );
endinterface

// File: rtl/csr_exec_unit.sv
// csr_exec_unit: Zicsr read-modify-write sequencer for the RV32I core.
// Drives the CSR file ports and owns the mcycle/minstret counters.
module csr_exec_unit #(
  parameter bit COUNTER_EN = 1'b1,
  parameter int CNT_W      = 64
) (
  input  logic           clock,
  input  logic           reset,
  csr_exec_unit_if.slave bus,
  input  logic           instret_pulse,
  output logic [11:0]    csr_r_addr,
  input  logic [31:0]    csr_r_val,
  output logic [11:0]    csr_w_addr,
  output logic [31:0]    csr_w_val,
  output logic           csr_w_enable
);

  typedef enum logic [1:0] {
    IDLE, READ, WRITE, RESP
  } state_t;

  state_t state_q, state_d;

  logic [2:0]  f3_q;
  logic [11:0] addr_q;
  logic [4:0]  idx_q;
  logic [4:0]  rd_q;
  logic [31:0] val_q;
  logic [31:0] old_q;
  logic        ill_q;

  logic [CNT_W-1:0] mcycle_q;
  logic [CNT_W-1:0] minstret_q;

  logic        op_rw, op_rs, op_rc;
  logic        do_write, illegal;
  logic [31:0] src, new_val;
  logic        cnt_page, is_cyc, is_ir;
  logic        cnt_hi, cnt_hit, cnt_wr;
  logic [63:0] cnt_cur, cnt_new;
  logic [31:0] cnt_rd;

  // decode the latched op: operand, new value, legality, counter hit
  always_comb begin
    op_rw    = f3_q[1:0] == 2'b01;
    op_rs    = f3_q[1:0] == 2'b10;
    op_rc    = f3_q[1:0] == 2'b11;
    src      = f3_q[2] ? {27'b0, idx_q} : val_q;
    do_write = op_rw || (idx_q != 5'd0);
    illegal  = !(op_rw || op_rs || op_rc)
            || (do_write && addr_q[11:10] == 2'b11);
    new_val  = old_q;
    unique case (1'b1)
      op_rw:   new_val = src;
      op_rs:   new_val = old_q | src;
      op_rc:   new_val = old_q & ~src;
      default: new_val = old_q;
    endcase
    cnt_page = (addr_q[11:8] == 4'hB)
            || (addr_q[11:8] == 4'hC);
    is_cyc   = addr_q[6:0] == 7'h00;
    is_ir    = addr_q[6:0] == 7'h02;
    cnt_hi   = addr_q[7];
    cnt_hit  = COUNTER_EN && cnt_page && (is_cyc || is_ir);
    cnt_cur  = is_ir ? 64'(minstret_q) : 64'(mcycle_q);
    cnt_rd   = cnt_hi ? cnt_cur[63:32] : cnt_cur[31:0];
    cnt_new  = cnt_hi ? {new_val, cnt_cur[31:0]}
                      : {cnt_cur[63:32], new_val};
    cnt_wr   = (state_q == WRITE) && cnt_hit
            && do_write && !ill_q;
  end

  // next state and port outputs
  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    csr_r_addr    = 12'd0;
    csr_w_enable  = 1'b0;
    csr_w_addr    = 12'd0;
    csr_w_val     = 32'd0;
    bus.rsp_valid   = 1'b0;
    bus.rsp_rd_idx  = 5'd0;
    bus.rsp_rd_val  = 32'd0;
    bus.rsp_illegal = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = READ;
      end
      READ: begin
        csr_r_addr = addr_q;
        state_d    = WRITE;
      end
      WRITE: begin
        if (!cnt_hit && do_write && !ill_q) begin
          csr_w_enable = 1'b1;
          csr_w_addr   = addr_q;
          csr_w_val    = new_val;
        end
        state_d = RESP;
      end
      RESP: begin
        bus.rsp_valid   = 1'b1;
        bus.rsp_rd_idx  = rd_q;
        bus.rsp_rd_val  = ill_q ? 32'd0 : old_q;
        bus.rsp_illegal = ill_q;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // request latch and old-value capture
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      f3_q   <= 3'd0;
      addr_q <= 12'd0;
      idx_q  <= 5'd0;
      val_q  <= 32'd0;
      rd_q   <= 5'd0;
      old_q  <= 32'd0;
      ill_q  <= 1'b0;
    end else if (state_q == IDLE && bus.req_valid) begin
      f3_q   <= bus.req_funct3;
      addr_q <= bus.req_csr_addr;
      idx_q  <= bus.req_rs1_idx;
      val_q  <= bus.req_rs1_val;
      rd_q   <= bus.req_rd_idx;
    end else if (state_q == READ) begin
      old_q <= cnt_hit ? cnt_rd : csr_r_val;
      ill_q <= illegal;
    end
  end

  // counters: a write in the same cycle replaces the increment
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (cnt_wr && !is_ir) mcycle_q <= CNT_W'(cnt_new);
      else                  mcycle_q <= mcycle_q + 1'b1;
      if (cnt_wr && is_ir)  minstret_q <= CNT_W'(cnt_new);
      else minstret_q <= minstret_q + CNT_W'(instret_pulse);
    end
  end

endmodule
